// File: rtl/array_heap_engine.sv
// Multi-array stack/heap engine: a shared block RAM carved into N_ARRAYS fixed slices,
// each with its own fill level, handled one command at a time through an IDLE/EXEC/RESP handshake.
module array_heap_engine #(
   parameter int WIDTH    = 12,
   parameter int N_ARRAYS = 4,
   parameter int N_AREA   = 8,
   localparam int AW = ($clog2(N_ARRAYS) > 1) ? $clog2(N_ARRAYS) : 1,
   localparam int IW = $clog2(N_AREA + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AW-1:0]    cmd_array,
   input  logic [IW-1:0]    cmd_index,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [2:0]       rsp_error,
   output logic [AW:0]      in_use,
   output logic [AW:0]      high_water
);

   localparam int DEPTH = N_ARRAYS * N_AREA;
   localparam int HAW   = $clog2(DEPTH);
   localparam logic [AW:0]   NARR  = (AW + 1)'(N_ARRAYS);
   localparam logic [IW-1:0] NAREA = IW'(N_AREA);

   localparam logic [2:0] OP_ALLOC = 3'd0, OP_FREE = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3,
                          OP_READ  = 3'd4, OP_WRITE = 3'd5, OP_SIZE = 3'd6;
   localparam logic [2:0] ERR_OK = 3'd0, ERR_FULL = 3'd1, ERR_EMPTY = 3'd2, ERR_RANGE = 3'd3,
                          ERR_NOMEM = 3'd4, ERR_BADOP = 3'd5;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t stateReg, stateNext;

   logic [2:0]       opReg;
   logic [AW-1:0]    arrayReg;
   logic [IW-1:0]    indexReg;
   logic [WIDTH-1:0] dataReg;

   logic [WIDTH-1:0] heap [0:DEPTH-1];
   logic [WIDTH-1:0] heapRdData;
   logic [IW-1:0]    sizes [0:N_ARRAYS-1];
   logic [N_ARRAYS-1:0] allocated;
   logic [AW-1:0]    freeStack [0:N_ARRAYS-1];
   logic [AW:0]      freeTop, freshId, inUse, highWater;

   logic             rspValid;
   logic [WIDTH-1:0] rspData;
   logic [2:0]       rspError;

   logic             accept, heapWe;
   logic [HAW-1:0]   rdAddr, wrAddr;
   logic [AW-1:0]    cmdIdx, arrIdx, allocId, popIdx;
   logic [IW-1:0]    cmdSize, curSize, rdOffset;
   logic             arrValid, allocFromStack;
   logic [2:0]       execErr;
   logic [WIDTH-1:0] execData;
   logic [AW:0]      inUseInc;

   // Out-of-range slices map to address 0; such commands always end in an error anyway.
   function automatic logic [HAW-1:0] heapAddr(input logic [AW-1:0] arr, input logic [IW-1:0] off);
      int unsigned a;
      a = 32'(arr) * 32'(N_AREA) + 32'(off);
      if (a >= 32'(DEPTH)) a = 0;
      return HAW'(a);
   endfunction

   // ---------------- control FSM ----------------
   always_ff @(posedge clock) begin
      if (reset) stateReg <= IDLE;
      else       stateReg <= stateNext;
   end

   always_comb begin
      stateNext = stateReg;
      cmd_ready = 1'b0;
      case (stateReg)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) stateNext = EXEC;
         end
         EXEC:    stateNext = RESP;
         RESP:    if (rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign accept = cmd_ready && cmd_valid;

   // ---------------- heap RAM: read launched on accept so EXEC sees the data ----------------
   assign cmdIdx   = ({1'b0, cmd_array} < NARR) ? cmd_array : '0;
   assign cmdSize  = sizes[cmdIdx];
   assign rdOffset = (cmd_op == OP_POP) ? cmdSize - 1'b1 : cmd_index;
   assign rdAddr   = heapAddr(cmd_array, rdOffset);

   assign arrIdx   = ({1'b0, arrayReg} < NARR) ? arrayReg : '0;
   assign curSize  = sizes[arrIdx];
   assign arrValid = ({1'b0, arrayReg} < NARR) && allocated[arrIdx];
   assign wrAddr   = heapAddr(arrayReg, (opReg == OP_PUSH) ? curSize : indexReg);

   always_ff @(posedge clock) begin
      if (heapWe) heap[wrAddr] <= dataReg;
      if (accept) heapRdData <= heap[rdAddr];
   end

   // ---------------- EXEC decode ----------------
   assign allocFromStack = (freeTop != '0);
   assign popIdx         = AW'(freeTop - 1'b1);
   assign allocId        = allocFromStack ? freeStack[popIdx] : freshId[AW-1:0];
   assign inUseInc       = inUse + 1'b1;

   always_comb begin
      execErr  = ERR_OK;
      execData = '0;
      heapWe   = 1'b0;
      case (opReg)
         OP_ALLOC: begin
            if (allocFromStack || freshId < NARR) execData = WIDTH'(allocId);
            else                                  execErr  = ERR_NOMEM;
         end
         OP_FREE:  if (!arrValid) execErr = ERR_RANGE;
         OP_PUSH: begin
            if (!arrValid)              execErr = ERR_RANGE;
            else if (curSize == NAREA)  execErr = ERR_FULL;
            else                        heapWe  = 1'b1;
         end
         OP_POP: begin
            if (!arrValid)              execErr  = ERR_RANGE;
            else if (curSize == '0)     execErr  = ERR_EMPTY;
            else                        execData = heapRdData;
         end
         OP_READ: begin
            if (!arrValid || indexReg >= curSize) execErr  = ERR_RANGE;
            else                                  execData = heapRdData;
         end
         OP_WRITE: begin
            if (!arrValid || indexReg >= NAREA) execErr = ERR_RANGE;
            else                                heapWe  = 1'b1;
         end
         OP_SIZE: begin
            if (!arrValid) execErr  = ERR_RANGE;
            else           execData = WIDTH'(curSize);
         end
         default: execErr = ERR_BADOP;
      endcase
      if (stateReg != EXEC || reset) heapWe = 1'b0;
   end

   // ---------------- command capture, bookkeeping and response ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         rspValid  <= 1'b0;
         rspData   <= '0;
         rspError  <= ERR_OK;
         inUse     <= '0;
         highWater <= '0;
         freeTop   <= '0;
         freshId   <= '0;
         allocated <= '0;
         for (int i = 0; i < N_ARRAYS; i++) sizes[i] <= '0;
      end else begin
         if (accept) begin
            opReg    <= cmd_op;
            arrayReg <= cmd_array;
            indexReg <= cmd_index;
            dataReg  <= cmd_data;
         end
         case (stateReg)
            EXEC: begin
               rspValid <= 1'b1;
               rspData  <= execData;
               rspError <= execErr;
               if (execErr == ERR_OK) begin
                  case (opReg)
                     OP_ALLOC: begin
                        if (allocFromStack) freeTop <= freeTop - 1'b1;
                        else                freshId <= freshId + 1'b1;
                        allocated[allocId] <= 1'b1;
                        sizes[allocId]     <= '0;
                        inUse              <= inUseInc;
                        if (inUseInc > highWater) highWater <= inUseInc;
                     end
                     OP_FREE: begin
                        allocated[arrIdx]             <= 1'b0;
                        freeStack[freeTop[AW-1:0]]    <= arrayReg;
                        freeTop                       <= freeTop + 1'b1;
                        inUse                         <= inUse - 1'b1;
                     end
                     OP_PUSH:  sizes[arrIdx] <= curSize + 1'b1;
                     OP_POP:   sizes[arrIdx] <= curSize - 1'b1;
                     OP_WRITE: if (indexReg >= curSize) sizes[arrIdx] <= indexReg + 1'b1;
                     default: ;
                  endcase
               end
            end
            RESP:    if (rsp_ready) rspValid <= 1'b0;
            default: ;
         endcase
      end
   end

   assign rsp_valid  = rspValid;
   assign rsp_data   = rspData;
   assign rsp_error  = rspError;
   assign in_use     = inUse;
   assign high_water = highWater;

endmodule
